// File: rtl/clock_monitor.sv
// Clock health monitor: classifies strobed frequency samples against a window,
// confirms the class over several samples, detects loss of samples, tracks min/max.
module clock_monitor #(
  parameter int CLK_MHZ           = 100,
  parameter int MSR_CLK_VAL_WIDTH = 32,
  parameter int CONFIRM_NUM       = 3,
  parameter int TIMEOUT_CYCLES    = 25000000
) (
  input  logic                         clk_i,
  input  logic                         a_rst_n_i,
  input  logic [MSR_CLK_VAL_WIDTH-1:0] msr_clk_val_i,
  input  logic                         msr_clk_vld_i,
  input  logic [MSR_CLK_VAL_WIDTH-1:0] min_val_i,
  input  logic [MSR_CLK_VAL_WIDTH-1:0] max_val_i,
  input  logic                         clr_i,
  output logic [2:0]                   state_o,
  output logic                         clk_ok_o,
  output logic                         err_sticky_o,
  output logic                         irq_o,
  output logic [MSR_CLK_VAL_WIDTH-1:0] last_val_o,
  output logic [MSR_CLK_VAL_WIDTH-1:0] min_seen_o,
  output logic [MSR_CLK_VAL_WIDTH-1:0] max_seen_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      CONFIRM_V = 4'(CONFIRM_NUM);

  if (CLK_MHZ < 1 || CONFIRM_NUM < 1 || CONFIRM_NUM > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("clock_monitor: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_OK   = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_LOST = 3'd4
  } state_e;

  state_e                       r_state, w_state_d;
  state_e                       r_cand, w_cand_d, w_cls;
  logic [3:0]                   r_cnt, w_cnt_d;
  logic [TO_W-1:0]              r_to_cnt, w_to_d;
  logic                         r_ok, r_err, r_irq;
  logic                         w_ok_d, w_err_d, w_irq_d, w_err_entry;
  logic [MSR_CLK_VAL_WIDTH-1:0] r_last, r_min, r_max;
  logic [MSR_CLK_VAL_WIDTH-1:0] w_last_d, w_min_d, w_max_d;

  // State register; every output is a flop so all of them move together.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state  <= ST_INIT;
      r_cand   <= ST_INIT;
      r_cnt    <= '0;
      r_to_cnt <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
      r_last   <= '0;
      r_min    <= '1;
      r_max    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cand   <= w_cand_d;
      r_cnt    <= w_cnt_d;
      r_to_cnt <= w_to_d;
      r_ok     <= w_ok_d;
      r_err    <= w_err_d;
      r_irq    <= w_irq_d;
      r_last   <= w_last_d;
      r_min    <= w_min_d;
      r_max    <= w_max_d;
    end
  end

  // Zero wins over the window so a dead meter is never reported as LOW.
  always_comb begin
    w_cls = ST_OK;
    if (msr_clk_val_i == '0)          w_cls = ST_LOST;
    else if (msr_clk_val_i < min_val_i) w_cls = ST_LOW;
    else if (msr_clk_val_i > max_val_i) w_cls = ST_HIGH;
  end

  // Next-state: confirmation on strobes, timeout only when no strobe arrives.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_cnt_d   = r_cnt;
    w_to_d    = r_to_cnt;
    if (msr_clk_vld_i) begin
      w_to_d = '0;
      if (w_cls == r_cand) begin
        if (r_cnt != CONFIRM_V) w_cnt_d = r_cnt + 4'd1;
      end else begin
        w_cand_d = w_cls;
        w_cnt_d  = 4'd1;
      end
      if (w_cnt_d == CONFIRM_V && w_cand_d != r_state) w_state_d = w_cand_d;
    end else if (r_to_cnt == TO_LAST) begin
      w_state_d = ST_LOST;
      w_cnt_d   = '0;
    end else begin
      w_to_d = r_to_cnt + 1'b1;
    end
  end

  // Output decode of the next state plus the sample trackers.
  always_comb begin
    w_irq_d     = (w_state_d != r_state);
    w_ok_d      = (w_state_d == ST_OK);
    w_err_entry = w_irq_d && (w_state_d inside {ST_LOW, ST_HIGH, ST_LOST});
    w_err_d     = r_err;
    if (w_err_entry) w_err_d = 1'b1;
    else if (clr_i)  w_err_d = 1'b0;

    w_last_d = r_last;
    w_min_d  = r_min;
    w_max_d  = r_max;
    if (msr_clk_vld_i) begin
      w_last_d = msr_clk_val_i;
      if (clr_i) begin
        w_min_d = msr_clk_val_i;
        w_max_d = msr_clk_val_i;
      end else begin
        if (msr_clk_val_i < r_min) w_min_d = msr_clk_val_i;
        if (msr_clk_val_i > r_max) w_max_d = msr_clk_val_i;
      end
    end else if (clr_i) begin
      w_min_d = '1;
      w_max_d = '0;
    end
  end

  assign state_o      = r_state;
  assign clk_ok_o     = r_ok;
  assign err_sticky_o = r_err;
  assign irq_o        = r_irq;
  assign last_val_o   = r_last;
  assign min_seen_o   = r_min;
  assign max_seen_o   = r_max;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed scenarios plus randomized traffic against a
// run-length based reference model.
module tb_clock_monitor;
  localparam int W       = 32;
  localparam int CONFIRM = 3;
  localparam int TIMEOUT = 100;

  logic          clk_i = 1'b0;
  logic          a_rst_n_i;
  logic [W-1:0]  msr_clk_val_i;
  logic          msr_clk_vld_i;
  logic [W-1:0]  min_val_i;
  logic [W-1:0]  max_val_i;
  logic          clr_i;
  logic [2:0]    state_o;
  logic          clk_ok_o, err_sticky_o, irq_o;
  logic [W-1:0]  last_val_o, min_seen_o, max_seen_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: run length of identical classes, quiet cycle count.
  int           m_state, m_cand, m_run, m_quiet;
  logic         m_irq, m_ok, m_err;
  logic [W-1:0] m_last, m_min, m_max;

  clock_monitor #(
    .CLK_MHZ(100), .MSR_CLK_VAL_WIDTH(W), .CONFIRM_NUM(CONFIRM), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .a_rst_n_i(a_rst_n_i),
    .msr_clk_val_i(msr_clk_val_i), .msr_clk_vld_i(msr_clk_vld_i),
    .min_val_i(min_val_i), .max_val_i(max_val_i), .clr_i(clr_i),
    .state_o(state_o), .clk_ok_o(clk_ok_o), .err_sticky_o(err_sticky_o), .irq_o(irq_o),
    .last_val_o(last_val_o), .min_seen_o(min_seen_o), .max_seen_o(max_seen_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_state = 0; m_cand = 0; m_run = 0; m_quiet = 0;
    m_irq = 1'b0; m_ok = 1'b0; m_err = 1'b0;
    m_last = '0; m_min = '1; m_max = '0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] val, input logic c);
    int prev, nxt, cls;
    prev = m_state;
    nxt  = prev;
    if (v) begin
      if (val == 0)             cls = 4;
      else if (val < min_val_i) cls = 2;
      else if (val > max_val_i) cls = 3;
      else                      cls = 1;
      if (cls == m_cand) m_run++;
      else begin m_cand = cls; m_run = 1; end
      if (m_run >= CONFIRM) nxt = m_cand;
      m_quiet = 0;
      m_last  = val;
      if (c) begin m_min = val; m_max = val; end
      else begin
        if (val < m_min) m_min = val;
        if (val > m_max) m_max = val;
      end
    end else begin
      m_quiet++;
      if (m_quiet >= TIMEOUT) begin nxt = 4; m_run = 0; end
      if (c) begin m_min = '1; m_max = '0; end
    end
    m_irq = (nxt != prev);
    m_ok  = (nxt == 1);
    if (nxt != prev && nxt >= 2) m_err = 1'b1;
    else if (c)                  m_err = 1'b0;
    m_state = nxt;
  endtask

  // One clock: inputs held across the edge, model follows, outputs settle by +1.
  task automatic tick(input logic v, input logic [W-1:0] val, input logic c);
    msr_clk_vld_i = v; msr_clk_val_i = val; clr_i = c;
    @(posedge clk_i);
    model_step(v, val, c);
    #1;
    msr_clk_vld_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic do_reset();
    a_rst_n_i = 1'b0;
    msr_clk_vld_i = 1'b0; clr_i = 1'b0; msr_clk_val_i = '0;
    model_reset();
    @(posedge clk_i); #1;
    a_rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_vec++; if ({clk_ok_o, err_sticky_o, irq_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {clk_ok_o, err_sticky_o, irq_o}); end
    n_vec++; if (min_seen_o !== '1 || max_seen_o !== '0 || last_val_o !== '0) begin n_err++; $display("FAIL reset_trackers: min %h max %h last %h", min_seen_o, max_seen_o, last_val_o); end
  endtask

  task automatic test_confirm_ok();
    int irqs = 0;
    do_reset();
    min_val_i = 90; max_val_i = 110;
    tick(1, 100, 0); irqs += int'(irq_o);
    tick(1, 100, 0); irqs += int'(irq_o);
    n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL ok_early: got %0d want 0", state_o); end
    tick(1, 100, 0); irqs += int'(irq_o);
    n_vec++; if (state_o !== 3'd1 || clk_ok_o !== 1'b1 || irq_o !== 1'b1) begin n_err++; $display("FAIL ok_enter: state %0d ok %b irq %b want 1 1 1", state_o, clk_ok_o, irq_o); end
    tick(0, 0, 0); irqs += int'(irq_o);
    tick(0, 0, 0); irqs += int'(irq_o);
    n_vec++; if (irqs !== 1 || err_sticky_o !== 1'b0) begin n_err++; $display("FAIL ok_irq: irqs %0d err %b want 1 0", irqs, err_sticky_o); end
  endtask

  task automatic test_low();
    tick(1, 80, 0); tick(1, 100, 0); tick(1, 80, 0); tick(1, 80, 0);
    n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL low_hold: got %0d want 1", state_o); end
    tick(1, 80, 0);
    n_vec++; if (state_o !== 3'd2 || err_sticky_o !== 1'b1 || clk_ok_o !== 1'b0) begin n_err++; $display("FAIL low_enter: state %0d err %b ok %b", state_o, err_sticky_o, clk_ok_o); end
    n_vec++; if (min_seen_o !== 32'd80 || max_seen_o !== 32'd100) begin n_err++; $display("FAIL low_minmax: min %0d max %0d want 80 100", min_seen_o, max_seen_o); end
  endtask

  task automatic test_timeout();
    int irqs = 0;
    do_reset();
    min_val_i = 90; max_val_i = 110;
    repeat (3) tick(1, 100, 0);
    repeat (TIMEOUT - 1) tick(0, 0, 0);
    n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL to_early: got %0d want 1", state_o); end
    tick(0, 0, 0);
    n_vec++; if (state_o !== 3'd4 || clk_ok_o !== 1'b0 || irq_o !== 1'b1) begin n_err++; $display("FAIL to_lost: state %0d ok %b irq %b want 4 0 1", state_o, clk_ok_o, irq_o); end
    repeat (20) begin tick(0, 0, 0); irqs += int'(irq_o); end
    n_vec++; if (irqs !== 0 || state_o !== 3'd4) begin n_err++; $display("FAIL to_once: extra irqs %0d state %0d", irqs, state_o); end
    do_reset();
    repeat (3) tick(1, 100, 0);
    repeat (TIMEOUT - 1) tick(0, 0, 0);
    tick(1, 100, 0);
    n_vec++; if (state_o !== 3'd1 || irq_o !== 1'b0) begin n_err++; $display("FAIL to_saved: state %0d irq %b want 1 0", state_o, irq_o); end
    repeat (TIMEOUT - 1) tick(0, 0, 0);
    n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL to_restart: got %0d want 1", state_o); end
  endtask

  task automatic test_clr_high();
    do_reset();
    min_val_i = 90; max_val_i = 110;
    repeat (3) tick(1, 100, 0);
    tick(1, 120, 0); tick(1, 120, 0);
    tick(1, 120, 1);
    n_vec++; if (state_o !== 3'd3 || err_sticky_o !== 1'b1) begin n_err++; $display("FAIL clr_high: state %0d err %b want 3 1", state_o, err_sticky_o); end
    n_vec++; if (min_seen_o !== 32'd120 || max_seen_o !== 32'd120) begin n_err++; $display("FAIL clr_load: min %0d max %0d want 120 120", min_seen_o, max_seen_o); end
    tick(0, 0, 1);
    n_vec++; if (err_sticky_o !== 1'b0 || min_seen_o !== '1 || max_seen_o !== '0) begin n_err++; $display("FAIL clr_only: err %b min %h max %h", err_sticky_o, min_seen_o, max_seen_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    min_val_i = 90; max_val_i = 110;
    tick(1, 100, 0); tick(1, 100, 0);
    a_rst_n_i = 1'b0;
    #1;
    n_vec++; if (last_val_o !== '0 || min_seen_o !== '1 || state_o !== 3'd0) begin n_err++; $display("FAIL rst_async: last %0d min %h state %0d", last_val_o, min_seen_o, state_o); end
    model_reset();
    @(posedge clk_i); #1;
    a_rst_n_i = 1'b1;
    tick(1, 100, 0);
    n_vec++; if (state_o !== 3'd0 || irq_o !== 1'b0) begin n_err++; $display("FAIL rst_partial: state %0d irq %b want 0 0", state_o, irq_o); end
  endtask

  task automatic test_min_gt_max();
    do_reset();
    min_val_i = 200; max_val_i = 100;
    repeat (3) tick(1, 150, 0);
    n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL inverted_window: got %0d want 2", state_o); end
    repeat (3) tick(1, 0, 0);
    n_vec++; if (state_o !== 3'd4 || err_sticky_o !== 1'b1) begin n_err++; $display("FAIL zero_lost: state %0d err %b want 4 1", state_o, err_sticky_o); end
  endtask

  task automatic test_random();
    int cls = 1;
    logic [W-1:0] val;
    logic v, c;
    do_reset();
    min_val_i = 1000; max_val_i = 2000;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin min_val_i = 1500; max_val_i = 1600; end
      if (i % 500 == 250) repeat (TIMEOUT + 5) tick(0, 0, 0);
      if ($urandom_range(0, 9) < 3) cls = $urandom_range(0, 3);
      case (cls)
        0:       val = '0;
        1:       val = ($urandom_range(0, 3) == 0) ? min_val_i - 1 : W'($urandom_range(1, 999));
        2:       case ($urandom_range(0, 3))
                   0: val = min_val_i;
                   1: val = max_val_i;
                   default: val = W'($urandom_range(min_val_i, max_val_i));
                 endcase
        default: val = ($urandom_range(0, 3) == 0) ? max_val_i + 1 : max_val_i + W'($urandom_range(1, 5000));
      endcase
      v = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 49) == 0);
      tick(v, val, c);
      n_vec++; if (state_o !== 3'(m_state)) begin n_err++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state_o, m_state); end
      n_vec++; if ({clk_ok_o, err_sticky_o, irq_o} !== {m_ok, m_err, m_irq}) begin n_err++; $display("FAIL rnd_flags @%0d: got %b want %b", i, {clk_ok_o, err_sticky_o, irq_o}, {m_ok, m_err, m_irq}); end
      n_vec++; if (last_val_o !== m_last || min_seen_o !== m_min || max_seen_o !== m_max) begin n_err++; $display("FAIL rnd_trackers @%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, last_val_o, min_seen_o, max_seen_o, m_last, m_min, m_max); end
    end
  endtask

  initial begin
    a_rst_n_i = 1'b0; msr_clk_vld_i = 1'b0; clr_i = 1'b0;
    msr_clk_val_i = '0; min_val_i = 90; max_val_i = 110;
    #2;
    test_reset();
    test_confirm_ok();
    test_low();
    test_timeout();
    test_clr_high();
    test_reset_mid();
    test_min_gt_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
